// File: rtl/urna_pkg.sv
// Shared types for the parametrised ballot box.
// State enum and VoteStatus encodings.
package urna_pkg;

   typedef enum logic [2:0] {
      S_READY  = 3'd0,
      S_ENTRY  = 3'd1,
      S_FULL   = 3'd2,
      S_ACK    = 3'd3,
      S_CLOSED = 3'd4
   } state_e;

   localparam logic [1:0] STAT_READY  = 2'd0;
   localparam logic [1:0] STAT_ENTRY  = 2'd1;
   localparam logic [1:0] STAT_ACK    = 2'd2;
   localparam logic [1:0] STAT_CLOSED = 2'd3;

endpackage

// File: rtl/urna_sat_counter.sv
// Saturating tally counter.
// sat_hit flags an increment attempted at the maximum value.
module urna_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             sat_hit
);

   logic [CNT_W-1:0] cnt_q;
   logic             full;

   assign full    = &cnt_q;
   assign sat_hit = inc & full;
   assign count   = cnt_q;

   // count up, holding at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (inc && !full)
         cnt_q <= cnt_q + CNT_W'(1);
   end

endmodule

// File: rtl/urna_param.sv
// Parametrised ballot box: BCD code entry, commit, tallies.
// Tallies stay hidden until the election is closed.
module urna_param
   import urna_pkg::*;
#(
   parameter int N_CAND      = 2,
   parameter int CODE_DIGITS = 2,
   parameter logic [N_CAND*CODE_DIGITS*4-1:0] CAND_CODES = 16'h4513,
   parameter int CNT_W       = 8,
   parameter int ACK_CYCLES  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [3:0]              digit,
   input  logic                    swap,
   input  logic                    cancel,
   input  logic                    valid,
   input  logic                    finish,
   output logic [1:0]              VoteStatus,
   output logic [N_CAND*CNT_W-1:0] contadorC,
   output logic [CNT_W-1:0]        contadorNull,
   output logic [CNT_W-1:0]        contadorTotal,
   output logic                    overflow
);

   localparam int EW   = CODE_DIGITS * 4;
   localparam int DCW  = $clog2(CODE_DIGITS + 1);
   localparam int AW   = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
   localparam int NCNT = N_CAND + 2;

   state_e          state_q, state_d;
   logic [EW-1:0]   entry_q, entry_d;
   logic [DCW-1:0]  dcnt_q, dcnt_d;
   logic [AW-1:0]   ack_q, ack_d;
   logic            overflow_q;

   logic              commit;
   logic              bcd_ok;
   logic              hit;
   logic              null_inc;
   logic [N_CAND-1:0] cand_inc;
   logic [NCNT-1:0]   inc_v, sat_v;
   logic [NCNT*CNT_W-1:0] cnt_v;
   logic              closed;

   // finish with valid in FULL still commits before closing
   assign commit = (state_q == S_FULL) && valid && (finish || !cancel);

   // entry is a legal BCD code only if every nibble is 0..9
   always_comb begin
      bcd_ok = 1'b1;
      for (int j = 0; j < CODE_DIGITS; j++)
         if (entry_q[j*4 +: 4] > 4'd9) bcd_ok = 1'b0;
   end

   // code comparators; the lowest matching candidate wins
   always_comb begin
      cand_inc = '0;
      hit      = 1'b0;
      for (int i = 0; i < N_CAND; i++) begin
         if (!hit && bcd_ok && entry_q == CAND_CODES[i*EW +: EW]) begin
            cand_inc[i] = commit;
            hit         = 1'b1;
         end
      end
   end

   assign null_inc = commit & ~hit;
   assign inc_v    = {commit, null_inc, cand_inc};

   genvar g;
   for (g = 0; g < NCNT; g++) begin : g_cnt
      urna_sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk     (clk),
         .rst_n   (rst_n),
         .inc     (inc_v[g]),
         .count   (cnt_v[g*CNT_W +: CNT_W]),
         .sat_hit (sat_v[g])
      );
   end

   // next-state: finish, then cancel, then valid, then swap
   always_comb begin
      state_d = state_q;
      entry_d = entry_q;
      dcnt_d  = dcnt_q;
      ack_d   = ack_q;
      if (state_q != S_CLOSED && finish) begin
         state_d = S_CLOSED;
         entry_d = '0;
         dcnt_d  = '0;
      end else begin
         unique case (state_q)
            S_READY, S_ENTRY: begin
               if (cancel) begin
                  state_d = S_READY;
                  entry_d = '0;
                  dcnt_d  = '0;
               end else if (swap) begin
                  entry_d = (entry_q << 4) | EW'(digit);
                  dcnt_d  = dcnt_q + DCW'(1);
                  state_d = (dcnt_d == DCW'(CODE_DIGITS)) ? S_FULL : S_ENTRY;
               end
            end
            S_FULL: begin
               if (cancel) begin
                  state_d = S_READY;
                  entry_d = '0;
                  dcnt_d  = '0;
               end else if (valid) begin
                  state_d = S_ACK;
                  entry_d = '0;
                  dcnt_d  = '0;
                  ack_d   = AW'(ACK_CYCLES - 1);
               end
            end
            S_ACK: begin
               if (ack_q == '0) state_d = S_READY;
               else ack_d = ack_q - AW'(1);
            end
            default: ;
         endcase
      end
   end

   // FSM, entry shift register, digit count and ACK timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_READY;
         entry_q <= '0;
         dcnt_q  <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         entry_q <= entry_d;
         dcnt_q  <= dcnt_d;
         ack_q   <= ack_d;
      end
   end

   // sticky overflow on any saturated increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow_q <= 1'b0;
      else if (|sat_v)
         overflow_q <= 1'b1;
   end

   // status decode; FULL still reports as entry in progress
   always_comb begin
      VoteStatus = STAT_READY;
      unique case (state_q)
         S_ENTRY, S_FULL: VoteStatus = STAT_ENTRY;
         S_ACK:           VoteStatus = STAT_ACK;
         S_CLOSED:        VoteStatus = STAT_CLOSED;
         default:         VoteStatus = STAT_READY;
      endcase
   end

   assign closed        = (state_q == S_CLOSED);
   assign contadorC     = closed ? cnt_v[N_CAND*CNT_W-1:0] : '0;
   assign contadorNull  = closed ? cnt_v[N_CAND*CNT_W +: CNT_W] : '0;
   assign contadorTotal = closed ? cnt_v[(N_CAND+1)*CNT_W +: CNT_W] : '0;
   assign overflow      = overflow_q;

endmodule
